// File: rtl/max_pkg.sv
// Shared definitions for the streaming max tracker: FSM encoding and frame-limit helper.
package max_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no frame open
    ACCUM = 2'd1,  // frame open, accumulating samples
    HOLD  = 2'd2   // result held until the consumer takes it
  } state_e;

  // Number of samples a frame may hold before it counts as overflowed.
  function automatic int frame_limit(input int idx_w);
    return 1 << idx_w;
  endfunction

endpackage

// File: rtl/max2_cmp.sv
// Strict a > b comparator: the two-input MAX decision, signed or unsigned.
module max2_cmp #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o
);

  // Compare at exactly WIDTH bits; signedness only changes interpretation.
  generate
    if (SIGNED) begin : gen_signed
      assign gt_o = $signed(a_i) > $signed(b_i);
    end else begin : gen_unsigned
      assign gt_o = a_i > b_i;
    end
  endgenerate

endmodule

// File: rtl/max_stream_tracker.sv
// Frame maximum tracker: consumes a valid/ready sample stream and reports the
// maximum of each frame with the index of its first occurrence.
module max_stream_tracker
  import max_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int IDX_W  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int                LIMIT    = frame_limit(IDX_W);
  localparam int                CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(LIMIT);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(LIMIT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   best_q, best_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   out_max_q, out_max_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic               out_ovf_q, out_ovf_d;

  logic               beat;
  logic               take;
  logic               gt;
  logic               at_limit;
  logic [IDX_W-1:0]   cand_idx;

  assign beat = in_valid && in_ready;
  assign take = out_valid && out_ready;

  max2_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a_i  (in_data),
    .b_i  (best_q),
    .gt_o (gt)
  );

  // Samples past the limit all map to the last representable index.
  assign at_limit = (cnt_q == CNT_MAX);
  assign cand_idx = at_limit ? IDX_LAST : cnt_q[IDX_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: open on first beat, close on last beat, release on take.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat) state_d = in_last ? HOLD : ACCUM;
      ACCUM:   if (beat && in_last) state_d = HOLD;
      HOLD:    if (take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded directly from state.
  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  // Running best / counter update; the first beat of a frame seeds everything.
  always_comb begin
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    ovf_d      = ovf_q;
    if (beat) begin
      if (state_q == IDLE) begin
        best_d     = in_data;
        best_idx_d = '0;
        cnt_d      = CNT_W'(1);
        ovf_d      = 1'b0;
      end else begin
        if (gt) begin
          best_d     = in_data;
          best_idx_d = cand_idx;
        end
        if (at_limit) ovf_d = 1'b1;
        else          cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Result capture: the last beat's own compare is folded in before loading.
  always_comb begin
    out_max_d = out_max_q;
    out_idx_d = out_idx_q;
    out_ovf_d = out_ovf_q;
    if (beat && in_last) begin
      out_max_d = best_d;
      out_idx_d = best_idx_d;
      out_ovf_d = ovf_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      ovf_q      <= 1'b0;
      out_max_q  <= '0;
      out_idx_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      ovf_q      <= ovf_d;
      out_max_q  <= out_max_d;
      out_idx_q  <= out_idx_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_max = out_max_q;
  assign out_idx = out_idx_q;
  assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_max_stream_tracker.sv
// Bench for max_stream_tracker: three instances (unsigned, signed, IDX_W=2)
// driven with directed and random frames, checked against a frame-level model.
module tb_max_stream_tracker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0][7:0] in_data;
  logic [2:0]      in_valid, in_last, out_ready;
  logic [2:0]      in_ready, out_valid, out_ovf;
  logic [2:0][7:0] out_max;
  logic [3:0]      idx0, idx1;
  logic [1:0]      idx2;

  int checks   = 0;
  int failures = 0;
  int sgn [3] = '{0, 1, 0};
  int lim [3] = '{16, 16, 4};
  logic [7:0] frame_q[$];

  max_stream_tracker #(.WIDTH(8), .IDX_W(4), .SIGNED(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .out_max(out_max[0]),
    .out_idx(idx0), .out_ovf(out_ovf[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]));

  max_stream_tracker #(.WIDTH(8), .IDX_W(4), .SIGNED(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .out_max(out_max[1]),
    .out_idx(idx1), .out_ovf(out_ovf[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]));

  max_stream_tracker #(.WIDTH(8), .IDX_W(2), .SIGNED(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_last(in_last[2]), .in_ready(in_ready[2]), .out_max(out_max[2]),
    .out_idx(idx2), .out_ovf(out_ovf[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_idx(input int k);
    if (k == 0) return {28'd0, idx0};
    if (k == 1) return {28'd0, idx1};
    return {30'd0, idx2};
  endfunction

  function automatic bit greater(input int k, input logic [7:0] a, input logic [7:0] b);
    if (sgn[k] != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Frame-level reference: scan for the first strict maximum, clamp its index.
  task automatic model(input int k, output logic [7:0] m, output int idx, output bit ovf);
    m   = frame_q[0];
    idx = 0;
    for (int i = 1; i < frame_q.size(); i++) begin
      if (greater(k, frame_q[i], m)) begin
        m   = frame_q[i];
        idx = (i < lim[k]) ? i : lim[k] - 1;
      end
    end
    ovf = (frame_q.size() > lim[k]);
  endtask

  task automatic check_reset_state(input int k, input string tag);
    check_eq({tag, "_out_valid"}, {31'd0, out_valid[k]}, 32'd0);
    check_eq({tag, "_in_ready"},  {31'd0, in_ready[k]},  32'd1);
    check_eq({tag, "_out_max"},   {24'd0, out_max[k]},   32'd0);
    check_eq({tag, "_out_idx"},   get_idx(k),            32'd0);
    check_eq({tag, "_out_ovf"},   {31'd0, out_ovf[k]},   32'd0);
  endtask

  // Drive frame_q into instance k (optionally with gaps), check the result
  // one cycle after the last beat, hold it for 'hold' cycles, then release.
  task automatic run_frame(input int k, input int hold, input bit gaps);
    logic [7:0] m;
    int idx;
    bit ovf;
    logic [7:0] s_max;
    logic [31:0] s_idx;
    model(k, m, idx, ovf);
    $display("frame inst=%0d len=%0d exp_max=%0h exp_idx=%0d exp_ovf=%0d hold=%0d",
             k, frame_q.size(), m, idx, ovf, hold);
    out_ready[k] = 1'b0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid[k] = 1'b0;
        in_data[k]  = 8'($urandom);
        in_last[k]  = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid[k] = 1'b1;
      in_data[k]  = frame_q[i];
      in_last[k]  = (i == frame_q.size() - 1);
      check_eq("beat_in_ready", {31'd0, in_ready[k]}, 32'd1);
      check_eq("beat_out_valid", {31'd0, out_valid[k]}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
    check_eq("lat1_out_valid", {31'd0, out_valid[k]}, 32'd1);
    check_eq("hold_in_ready", {31'd0, in_ready[k]}, 32'd0);
    check_eq("out_max", {24'd0, out_max[k]}, {24'd0, m});
    check_eq("out_idx", get_idx(k), 32'(idx));
    check_eq("out_ovf", {31'd0, out_ovf[k]}, {31'd0, ovf});
    s_max = out_max[k];
    s_idx = get_idx(k);
    for (int c = 0; c < hold; c++) begin
      in_valid[k] = 1'b1;
      in_data[k]  = 8'($urandom);
      in_last[k]  = 1'($urandom);
      @(posedge clk); #1;
      check_eq("bp_out_valid", {31'd0, out_valid[k]}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready[k]}, 32'd0);
      check_eq("bp_max_stable", {24'd0, out_max[k]}, {24'd0, s_max});
      check_eq("bp_idx_stable", get_idx(k), s_idx);
    end
    in_valid[k]  = 1'b0;
    in_last[k]   = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check_eq("rel_out_valid", {31'd0, out_valid[k]}, 32'd0);
    check_eq("rel_in_ready", {31'd0, in_ready[k]}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_reset_state(k, "reset");
    rst = 1'b0;

    // Unsigned frame with a tie, then the same frame under backpressure.
    frame_q = '{8'd3, 8'd9, 8'd9, 8'd2};
    run_frame(0, 0, 1'b0);
    run_frame(0, 5, 1'b0);

    // Signed versus unsigned interpretation of the same bytes.
    frame_q = '{8'hF0, 8'h05, 8'h80};
    run_frame(1, 0, 1'b0);
    run_frame(0, 0, 1'b0);

    // Overflow on the small-index instance; exactly-full frame does not overflow.
    frame_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7};
    run_frame(2, 0, 1'b0);
    frame_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_frame(2, 0, 1'b0);
    frame_q = '{8'd9};
    run_frame(2, 1, 1'b0);

    // Reset mid-frame discards the partial frame.
    in_valid[0] = 1'b1; in_last[0] = 1'b0;
    in_data[0] = 8'd5; @(posedge clk); #1;
    in_data[0] = 8'd6; @(posedge clk); #1;
    in_valid[0] = 1'b0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check_reset_state(0, "rst_mid");
    frame_q = '{8'd1};
    run_frame(0, 0, 1'b0);

    // Reset while a result is held.
    in_valid[0] = 1'b1; in_last[0] = 1'b1; in_data[0] = 8'd200;
    @(posedge clk); #1;
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    check_eq("pre_rst_hold", {31'd0, out_valid[0]}, 32'd1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check_reset_state(0, "rst_hold");

    // Random frames on every instance; narrow value ranges force ties.
    for (int t = 0; t < 60; t++) begin
      int k;
      int n;
      int narrow;
      k = t % 3;
      n = $urandom_range(1, 20);
      narrow = $urandom_range(0, 1);
      frame_q = {};
      for (int i = 0; i < n; i++)
        frame_q.push_back(narrow != 0 ? 8'($urandom_range(0, 7)) : 8'($urandom));
      run_frame(k, $urandom_range(0, 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
